// File: rtl/mips150_mem_arbiter.sv
// mips150_mem_arbiter
// Shares one single-ported memory between the MIPS150 instruction-fetch port
// and the load/store port. One transaction at a time is latched onto the
// mem_* bus and held until mem_ack. Data normally wins a contested
// arbitration. A starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants made while fetch was waiting.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add an acknowledge watchdog.
// After TIMEOUT_CYCLES busy cycles without mem_ack, the transaction is
// aborted. The requester then sees rvalid with zero data, and err pulses.

module mips150_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // shared memory port
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  // Width is chosen so that the counter can hold STARVE_LIMIT itself.
  localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_i_gnt;
  logic              r_i_rvalid;
  logic [31:0]       r_i_rdata;
  logic              r_d_gnt;
  logic              r_d_rvalid;
  logic [31:0]       r_d_rdata;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_we;
  logic [31:0]       r_mem_wdata;

  logic              w_idle;
  logic              w_starved;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_ack;
  logic              w_tmo;

  // Arbitration decode: grants are only made from IDLE, data wins unless fetch is starved
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_starved = (r_starve_cnt == SC_MAX);
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_idle) begin
      if (i_req && (!d_req || w_starved)) begin
        w_grant_i = 1'b1;
      end else if (d_req) begin
        w_grant_d = 1'b1;
      end else begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
      end
    end else begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  // Completion decode: an acknowledge only counts while a transaction is outstanding
  always_comb begin
    if (w_idle) begin
      w_ack = 1'b0;
    end else begin
      w_ack = mem_ack;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int            TC_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);

  logic [TC_W-1:0] r_tmo_cnt;
  logic            r_err;

  // Watchdog fires on the busy cycle whose count would reach TIMEOUT_CYCLES; ack has priority
  always_comb begin
    if (!w_idle && !mem_ack && (r_tmo_cnt == TC_LAST)) begin
      w_tmo = 1'b1;
    end else begin
      w_tmo = 1'b0;
    end
  end

  // Watchdog counter: cleared on every grant, counts busy cycles without ack
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt <= {TC_W{1'b0}};
    end else if (w_grant_i || w_grant_d) begin
      r_tmo_cnt <= {TC_W{1'b0}};
    end else if (!w_idle && !mem_ack && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + {{(TC_W-1){1'b0}}, 1'b1};
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  // Error flag: one-cycle pulse alongside the aborting rvalid
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
    end
  end

  assign err = r_err;
`else
  // No watchdog: a busy transaction waits for mem_ack indefinitely
  always_comb begin
    w_tmo = 1'b0;
  end
`endif

  // Starvation counter: counts data grants that overtook a waiting fetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= {SC_W{1'b0}};
    end else if (w_grant_i) begin
      r_starve_cnt <= {SC_W{1'b0}};
    end else if (w_grant_d && i_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + {{(SC_W-1){1'b0}}, 1'b1};
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Main FSM: capture payload on grant, hold the bus, return read data on ack or abort
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_i_gnt     <= 1'b0;
      r_i_rvalid  <= 1'b0;
      r_i_rdata   <= 32'h0000_0000;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= 32'h0000_0000;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_we    <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      // grant and rvalid are single-cycle pulses unless re-asserted below
      r_i_gnt    <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_i) begin
            r_state     <= ST_BUSY_I;
            r_i_gnt     <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= i_addr;
            r_mem_we    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
          end else if (w_grant_d) begin
            r_state     <= ST_BUSY_D;
            r_d_gnt     <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= d_addr;
            r_mem_we    <= d_we;
            r_mem_wdata <= d_wdata;
          end else begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        ST_BUSY_I: begin
          if (w_ack) begin
            r_state    <= ST_IDLE;
            r_i_rvalid <= 1'b1;
            r_i_rdata  <= mem_rdata;
            r_mem_req  <= 1'b0;
          end else if (w_tmo) begin
            r_state    <= ST_IDLE;
            r_i_rvalid <= 1'b1;
            r_i_rdata  <= 32'h0000_0000;
            r_mem_req  <= 1'b0;
          end else begin
            r_state   <= ST_BUSY_I;
            r_mem_req <= 1'b1;
          end
        end
        ST_BUSY_D: begin
          if (w_ack) begin
            r_state    <= ST_IDLE;
            r_d_rvalid <= 1'b1;
            r_d_rdata  <= mem_rdata;
            r_mem_req  <= 1'b0;
          end else if (w_tmo) begin
            r_state    <= ST_IDLE;
            r_d_rvalid <= 1'b1;
            r_d_rdata  <= 32'h0000_0000;
            r_mem_req  <= 1'b0;
          end else begin
            r_state   <= ST_BUSY_D;
            r_mem_req <= 1'b1;
          end
        end
        default: begin
          // unreachable encoding: recover to a quiet bus
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt     = r_i_gnt;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mips150_mem_arbiter.sv
// Directed bench for mips150_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
// The watchdog section is built only when MEM_ARB_TIMEOUT_EN is defined.

module tb_mips150_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err;
`endif

  int n_vec;
  int n_err;

  mips150_mem_arbiter #(
    .ADDR_W(32),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_gnt(i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_addr(d_addr),
    .d_we(d_we),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .err(err)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_order [10];
    logic [7:0] got;
    int n_gnt;

    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    i_req = 1'b0;  i_addr = 32'h0;
    d_req = 1'b0;  d_addr = 32'h0;  d_we = 4'b0000;  d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    rst = 1'b1;

    // ---- reset state
    check("rst_i_gnt", {63'd0, i_gnt}, 64'd0);
    check("rst_d_gnt", {63'd0, d_gnt}, 64'd0);
    check("rst_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    check("rst_mem_we", {60'd0, mem_we}, 64'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    check("rst_state", {62'd0, dut.r_state}, 64'd0);

    // ---- fetch only, ack two cycles after mem_req
    i_req = 1'b1; i_addr = 32'h0000_0100;
    step();
    check("f_i_gnt", {63'd0, i_gnt}, 64'd1);
    check("f_mem_req", {63'd0, mem_req}, 64'd1);
    check("f_mem_addr", {32'd0, mem_addr}, 64'h100);
    check("f_mem_we", {60'd0, mem_we}, 64'd0);
    i_req = 1'b0;
    step();
    check("f_gnt_pulse", {63'd0, i_gnt}, 64'd0);
    check("f_mem_req_hold", {63'd0, mem_req}, 64'd1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h2408_0005;
    check("f_no_early_rvalid", {63'd0, i_rvalid}, 64'd0);
    step();
    check("f_i_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd2);
    check("f_i_rdata", {32'd0, i_rdata}, 64'h2408_0005);
    check("f_mem_req_drop", {63'd0, mem_req}, 64'd0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    check("f_rvalid_pulse", {63'd0, i_rvalid}, 64'd0);
    check("f_rdata_hold", {32'd0, i_rdata}, 64'h2408_0005);

    // ---- store, zero-wait ack
    d_req = 1'b1; d_we = 4'b0011; d_wdata = 32'hCAFE_BABE; d_addr = 32'h0000_2004;
    step();
    check("s_d_gnt", {62'd0, i_gnt, d_gnt}, 64'd1);
    check("s_mem_we", {60'd0, mem_we}, 64'h3);
    check("s_mem_wdata", {32'd0, mem_wdata}, 64'hCAFE_BABE);
    check("s_mem_addr", {32'd0, mem_addr}, 64'h2004);
    d_req = 1'b0; d_we = 4'b0000; d_wdata = 32'h0; d_addr = 32'h0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    check("s_d_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd1);
    check("s_d_rdata", {32'd0, d_rdata}, 64'h1111_1111);
    check("s_mem_req_drop", {63'd0, mem_req}, 64'd0);
    check("s_i_rdata_kept", {32'd0, i_rdata}, 64'h2408_0005);
    mem_ack = 1'b0;
    step();

    // ---- contention, both requesters always pending, zero-wait memory
    exp_order[0] = "D"; exp_order[1] = "D"; exp_order[2] = "D"; exp_order[3] = "D";
    exp_order[4] = "I"; exp_order[5] = "D"; exp_order[6] = "D"; exp_order[7] = "D";
    exp_order[8] = "D"; exp_order[9] = "I";
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_req = 1'b1; d_addr = 32'h0000_0080; d_we = 4'b0000;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    n_gnt = 0;
    for (int cyc = 0; cyc < 60 && n_gnt < 10; cyc++) begin
      step();
      if (i_gnt || d_gnt) begin
        got = i_gnt ? 8'h49 : 8'h44;
        check("c_single_gnt", {63'd0, i_gnt & d_gnt}, 64'd0);
        check("c_order", {56'd0, got}, {56'd0, exp_order[n_gnt]});
        if (i_gnt) begin
          check("c_starve_clr", {61'd0, dut.r_starve_cnt}, 64'd0);
          check("c_i_addr", {32'd0, mem_addr}, 64'h40);
        end else begin
          check("c_d_addr", {32'd0, mem_addr}, 64'h80);
        end
        n_gnt++;
      end
    end
    check("c_grant_count", 64'(n_gnt), 64'd10);
    i_req = 1'b0; d_req = 1'b0;
    step();
    mem_ack = 1'b0;
    step();
    check("c_idle_after", {62'd0, dut.r_state}, 64'd0);

    // ---- reset in the middle of a data transaction
    d_req = 1'b1; d_addr = 32'h0000_3000; d_we = 4'b1111; d_wdata = 32'h1234_5678;
    step();
    check("r_d_gnt", {63'd0, d_gnt}, 64'd1);
    d_req = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    check("r_outs_zero", {mem_addr, mem_wdata}, 64'd0);
    check("r_ctl_zero", {56'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_we}, 64'd0);
    check("r_state_idle", {62'd0, dut.r_state}, 64'd0);
    step();
    check("r_no_rvalid", {61'd0, mem_req, i_rvalid, d_rvalid}, 64'd0);
    check("r_rdata_zero", {i_rdata, d_rdata}, 64'd0);
    check("r_starve_zero", {61'd0, dut.r_starve_cnt}, 64'd0);
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // ---- data request raised during a fetch and withdrawn before any grant
    i_req = 1'b1; i_addr = 32'h0000_0200;
    step();
    check("w_i_gnt", {62'd0, i_gnt, d_gnt}, 64'd2);
    i_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_5000; d_we = 4'b1111; d_wdata = 32'h5555_5555;
    step();
    d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0ABC;
    step();
    check("w_i_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd2);
    check("w_i_rdata", {32'd0, i_rdata}, 64'hABC);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("w_no_d_gnt", {62'd0, d_gnt, mem_req}, 64'd0);
    end
    check("w_addr_kept", {32'd0, mem_addr}, 64'h200);

`ifdef MEM_ARB_TIMEOUT_EN
    // ---- load that completes normally, then one that is never acknowledged
    d_req = 1'b1; d_addr = 32'h0000_6000; d_we = 4'b0000;
    step();
    d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hABCD_0123;
    step();
    check("t_pre_rdata", {32'd0, d_rdata}, 64'hABCD_0123);
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    d_req = 1'b1; d_addr = 32'h0000_6004;
    step();
    check("t_d_gnt", {63'd0, d_gnt}, 64'd1);
    d_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t_waiting", {61'd0, err, d_rvalid, mem_req}, 64'd1);
    end
    step();
    check("t_abort", {61'd0, err, d_rvalid, mem_req}, 64'd6);
    check("t_rdata_zero", {32'd0, d_rdata}, 64'd0);
    step();
    check("t_err_pulse", {62'd0, err, d_rvalid}, 64'd0);
    d_req = 1'b1; d_addr = 32'h0000_6008;
    step();
    check("t_next_gnt", {62'd0, d_gnt, mem_req}, 64'd3);
    d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    step();
    check("t_next_done", {31'd0, err, d_rvalid, d_rdata}, {31'd0, 1'b0, 1'b1, 32'h0F0F_0F0F});
    mem_ack = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
